// File: rtl/lcd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lcd_ctrl_pkg
// Shared definitions for the HD44780-class character LCD write sequencer:
//   - lcd_state_e   : sequencer FSM states
//   - LCD_*_BIT     : bit positions inside the 32-bit io_lcd_o pin word
//   - LCD_INIT_SEQ  : power-on command bytes issued before any user request
//   - is_clear_cmd  : picks the long post-write wait for clear/home commands
// No ports (package).
// ---------------------------------------------------------------------------
package lcd_ctrl_pkg;

    localparam int TIMER_W = 20;

    // ST_LOAD is the one-cycle slot between accepting a byte and driving it
    // onto the bus; ST_INIT plays the same role for the init ROM bytes.
    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } lcd_state_e;

    localparam int LCD_ON_BIT = 31;
    localparam int LCD_EN_BIT = 10;
    localparam int LCD_RS_BIT = 9;
    localparam int LCD_RW_BIT = 8;

    // Function set 8-bit/2-line, display on, clear, entry mode increment.
    localparam logic [7:0] LCD_INIT_SEQ [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    // Clear display / return home need the long execution wait.
    function automatic logic is_clear_cmd(input logic rs, input logic [7:0] data);
        return (!rs) && (data >= 8'h01) && (data <= 8'h03);
    endfunction

endpackage

// File: rtl/lcd_req_fifo.sv
// ---------------------------------------------------------------------------
// lcd_req_fifo
// Small synchronous request FIFO placed in front of the LCD sequencer when
// the build enables buffering. Head entry is always visible on rdata_o.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset (empties the FIFO)
//   push_i        : write wdata_i (ignored when full)
//   wdata_i       : entry to store
//   pop_i         : drop the head entry (ignored when empty)
//   rdata_o       : head entry
//   full_o        : no free slot
//   empty_o       : no stored entry
// ---------------------------------------------------------------------------
module lcd_req_fifo
    import lcd_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/lcd_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_ctrl
// Write-only sequencer for an HD44780-class character LCD. After power-on it
// waits, issues the fixed init command bytes, then accepts command/data bytes
// and generates setup / EN pulse / hold / execution-wait timing for each.
// Optional build macro: LCD_CTRL_FIFO_EN adds a 4-entry request FIFO so
// requests can be queued (also during init) and drained in order.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   req_valid_i    : request valid
//   req_ready_o    : request accepted when valid & ready at a rising edge
//   req_rs_i       : 0 = command, 1 = data
//   req_data_i     : byte to write
//   busy_o         : sequencer not idle (or FIFO holds entries)
//   init_done_o    : init sequence finished, sticky until reset
//   io_lcd_o       : {ON[31], 20'b0, EN[10], RS[9], RW[8], DATA[7:0]}
// ---------------------------------------------------------------------------
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int SETUP_CYC     = 2,
    parameter int PULSE_CYC     = 12,
    parameter int HOLD_CYC      = 2,
    parameter int CMD_WAIT_CYC  = 2000,
    parameter int CLR_WAIT_CYC  = 82000,
    parameter int INIT_WAIT_CYC = 750000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_rs_i,
    input  logic [7:0]  req_data_i,
    output logic        busy_o,
    output logic        init_done_o,
    output logic [31:0] io_lcd_o
);

    // Each timed state loads N-1 on entry and leaves when the count hits 0.
    localparam logic [TIMER_W-1:0] SETUP_LD = TIMER_W'(SETUP_CYC - 1);
    localparam logic [TIMER_W-1:0] PULSE_LD = TIMER_W'(PULSE_CYC - 1);
    localparam logic [TIMER_W-1:0] HOLD_LD  = TIMER_W'(HOLD_CYC - 1);
    localparam logic [TIMER_W-1:0] CMD_LD   = TIMER_W'(CMD_WAIT_CYC - 1);
    localparam logic [TIMER_W-1:0] CLR_LD   = TIMER_W'(CLR_WAIT_CYC - 1);
    localparam logic [TIMER_W-1:0] INIT_LD  = TIMER_W'(INIT_WAIT_CYC - 1);

    lcd_state_e         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         init_idx_q, init_idx_d;
    logic               init_done_q, init_done_d;
    logic               ready_q, ready_d;
    logic               on_q, on_d;
    logic               en_q, en_d;
    logic               rs_q, rs_d;
    logic [7:0]         data_q, data_d;
    logic               lat_rs_q, lat_rs_d;
    logic [7:0]         lat_data_q, lat_data_d;

    logic               timer_zero;
    logic               take;
    logic               take_rs;
    logic [7:0]         take_data;

    assign timer_zero = (timer_q == '0);

`ifdef LCD_CTRL_FIFO_EN
    logic       fifo_full, fifo_empty, fifo_push;
    logic [8:0] fifo_rdata;

    // ready_q is only set in IDLE after init, so the FIFO drains after init.
    assign req_ready_o = on_q && !fifo_full;
    assign fifo_push   = req_valid_i && req_ready_o;
    assign take        = ready_q && !fifo_empty;
    assign take_rs     = fifo_rdata[8];
    assign take_data   = fifo_rdata[7:0];
    assign busy_o      = (state_q != ST_IDLE) || !fifo_empty;

    lcd_req_fifo #(
        .DEPTH (4),
        .WIDTH (9)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .wdata_i ({req_rs_i, req_data_i}),
        .pop_i   (take),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
`else
    assign req_ready_o = ready_q;
    assign take        = ready_q && req_valid_i;
    assign take_rs     = req_rs_i;
    assign take_data   = req_data_i;
    assign busy_o      = (state_q != ST_IDLE);
`endif

    assign init_done_o = init_done_q;

    always_comb begin
        io_lcd_o             = '0;
        io_lcd_o[LCD_ON_BIT] = on_q;
        io_lcd_o[LCD_EN_BIT] = en_q;
        io_lcd_o[LCD_RS_BIT] = rs_q;
        io_lcd_o[LCD_RW_BIT] = 1'b0;
        io_lcd_o[7:0]        = data_q;
    end

    // Next-state and next-output logic; bus pins only change on transitions,
    // so RS/DATA stay put from SETUP through HOLD and the following WAIT.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        ready_d     = ready_q;
        on_d        = 1'b1;
        en_d        = en_q;
        rs_d        = rs_q;
        data_d      = data_q;
        lat_rs_d    = lat_rs_q;
        lat_data_d  = lat_data_q;

        case (state_q)
            ST_PWR_WAIT: begin
                if (timer_zero) state_d = ST_INIT;
                else            timer_d = timer_q - TIMER_W'(1);
            end
            ST_INIT: begin
                state_d = ST_SETUP;
                timer_d = SETUP_LD;
                rs_d    = 1'b0;
                data_d  = LCD_INIT_SEQ[init_idx_q];
            end
            ST_IDLE: begin
                if (take) begin
                    lat_rs_d   = take_rs;
                    lat_data_d = take_data;
                    ready_d    = 1'b0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_SETUP;
                timer_d = SETUP_LD;
                rs_d    = lat_rs_q;
                data_d  = lat_data_q;
            end
            ST_SETUP: begin
                if (timer_zero) begin
                    state_d = ST_PULSE;
                    timer_d = PULSE_LD;
                    en_d    = 1'b1;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_PULSE: begin
                if (timer_zero) begin
                    state_d = ST_HOLD;
                    timer_d = HOLD_LD;
                    en_d    = 1'b0;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_HOLD: begin
                if (timer_zero) begin
                    state_d = ST_WAIT;
                    timer_d = is_clear_cmd(rs_q, data_q) ? CLR_LD : CMD_LD;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_WAIT: begin
                if (!timer_zero) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else if (init_done_q || init_idx_q == 2'd3) begin
                    init_done_d = 1'b1;
                    ready_d     = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    init_idx_d = init_idx_q + 2'd1;
                    state_d    = ST_INIT;
                end
            end
            default: begin
                state_d = ST_PWR_WAIT;
                timer_d = INIT_LD;
            end
        endcase
    end

    // Reset drops EN immediately and discards any latched request; the full
    // power-on wait and init sequence then rerun.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_PWR_WAIT;
            timer_q     <= INIT_LD;
            init_idx_q  <= '0;
            init_done_q <= 1'b0;
            ready_q     <= 1'b0;
            on_q        <= 1'b0;
            en_q        <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= '0;
            lat_rs_q    <= 1'b0;
            lat_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            ready_q     <= ready_d;
            on_q        <= on_d;
            en_q        <= en_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            lat_rs_q    <= lat_rs_d;
            lat_data_q  <= lat_data_d;
        end
    end

endmodule
